// File: rtl/deserializer_pkg.sv
// Shared types and default sizing for the deserializer block.
// The two-state FSM type is used by the control sub-module and exported
// on the top-level debug port so checkers can observe the frame phase.
package deserializer_pkg;

    localparam int DEFAULT_BIT_WIDTH = 32;
    localparam int DEFAULT_N_SAMPLES = 8;

    // COLLECT: filling slots from the serial input.
    // HOLD:    a complete frame is presented downstream and held stable.
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/deserializer_control.sv
// Control path of the deserializer: frame FSM, slot counter and one write
// enable per slot. The slot index is the counter value, which is always 0
// while a frame is held, so an accepted sample in HOLD lands in slot 0.
// Build option: DESERIALIZER_OVERLAP_EN lets HOLD accept the first sample of
// the next frame in the same cycle the held frame is consumed.
module deserializer_control
    import deserializer_pkg::*;
#(
    parameter int N_SAMPLES = DEFAULT_N_SAMPLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    input  logic                 send_rdy,
    output logic                 recv_rdy,
    output logic                 send_val,
    output logic [N_SAMPLES-1:0] wr_en,
    output state_t               state
);

    localparam int            CW   = $clog2(N_SAMPLES);
    localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

    logic [CW-1:0] count;
    logic          collect_q;   // registered "in COLLECT" flag, drives recv_rdy
    logic          hs;          // sample handshake this cycle

`ifdef DESERIALIZER_OVERLAP_EN
    // While holding, accept a new sample exactly when the held frame leaves.
    assign recv_rdy = collect_q | (send_val & send_rdy);
`else
    // While holding, refuse input: one bubble cycle between frames.
    assign recv_rdy = collect_q;
`endif

    assign hs = recv_val & recv_rdy;

    // One write enable per slot, selected by the current count.
    for (genvar i = 0; i < N_SAMPLES; i++) begin : g_wr_en
        assign wr_en[i] = hs && (count == CW'(i));
    end

    // Frame FSM with registered recv_rdy/send_val flags and the slot counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= COLLECT;
            count     <= '0;
            collect_q <= 1'b1;
            send_val  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (hs) begin
                        if (count == LAST) begin
                            count     <= '0;
                            state     <= HOLD;
                            collect_q <= 1'b0;
                            send_val  <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // hs can only be high here in the overlap build; count is 0.
                    if (hs) begin
                        count <= count + 1'b1;
                    end
                    if (send_rdy) begin
                        state     <= COLLECT;
                        collect_q <= 1'b1;
                        send_val  <= 1'b0;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    collect_q <= 1'b1;
                    send_val  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_en_reset.sv
// Register library: enable register with asynchronous active-low reset to zero.
// Loads d on a rising clock edge when en is high, otherwise keeps its value.
module reg_en_reset #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear immediately on reset, load on enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/deserializer.sv
// Deserializer: gathers N_SAMPLES serial samples into one parallel frame.
// send_msg comes straight from the slot registers; there is no combinational
// path from recv_msg to send_msg.
// Build option: DESERIALIZER_OVERLAP_EN (back-to-back frames without a bubble).
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. Valid must not depend on ready; the payload is only meaningful
// while valid is high. recv side moves one sample, send side moves one frame.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int N_SAMPLES = DEFAULT_N_SAMPLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES],
    output logic                 send_val,
    input  logic                 send_rdy,
    output state_t               dbg_state
);

    logic [N_SAMPLES-1:0] wr_en;

    deserializer_control #(
        .N_SAMPLES (N_SAMPLES)
    ) u_control (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .send_rdy (send_rdy),
        .recv_rdy (recv_rdy),
        .send_val (send_val),
        .wr_en    (wr_en),
        .state    (dbg_state)
    );

    // Slot i captures recv_msg only on the handshake that targets it.
    for (genvar i = 0; i < N_SAMPLES; i++) begin : g_slot
        reg_en_reset #(
            .WIDTH (BIT_WIDTH)
        ) u_slot (
            .clk   (clk),
            .reset (reset),
            .en    (wr_en[i]),
            .d     (recv_msg),
            .q     (send_msg[i])
        );
    end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for the deserializer (BIT_WIDTH=32, N_SAMPLES=8).
// A frame-level model tracks which samples have been accepted and what each
// slot must hold; a per-cycle compare checks the DUT against it, and directed
// scenarios pin literal values. Honors DESERIALIZER_OVERLAP_EN.
module tb_deserializer;
    import deserializer_pkg::*;

    localparam int BW = 32;
    localparam int N  = 8;
`ifdef DESERIALIZER_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] recv_msg;
    logic          recv_val;
    logic          recv_rdy;
    logic [BW-1:0] send_msg [N];
    logic          send_val;
    logic          send_rdy;
    state_t        dbg_state;

    always #5 clk = ~clk;

    deserializer #(
        .BIT_WIDTH (BW),
        .N_SAMPLES (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .recv_msg  (recv_msg),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .send_msg  (send_msg),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // m_frame: samples accepted so far for the frame being built.
    // m_full:  a complete frame is waiting for the consumer.
    // m_slot:  what each output element must show.
    logic [BW-1:0] m_slot [N] = '{default: '0};
    logic [BW-1:0] m_frame [$];
    bit            m_full = 1'b0;
    bit            m_hs;

    function automatic bit m_rdy();
        return !m_full || (OVERLAP && send_rdy);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_full = 1'b0;
            m_frame.delete();
            for (int i = 0; i < N; i++) m_slot[i] = '0;
        end else begin
            m_hs = recv_val && m_rdy();
            if (m_full && send_rdy) m_full = 1'b0;
            if (m_hs) begin
                m_slot[m_frame.size()] = recv_msg;
                m_frame.push_back(recv_msg);
                if (m_frame.size() == N) begin
                    m_full = 1'b1;
                    m_frame.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cyc_recv_rdy", recv_rdy, m_rdy());
        check("cyc_send_val", send_val, m_full);
        for (int i = 0; i < N; i++) begin
            check($sformatf("cyc_send_msg[%0d]", i), send_msg[i], m_slot[i]);
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [BW-1:0] m, input logic s);
        recv_val = v;
        recv_msg = m;
        send_rdy = s;
        step();
    endtask

    // Offer one sample until accepted; stalls counts cycles it was refused.
    task automatic push(input logic [BW-1:0] d, input logic s, output int stalls);
        bit done;
        done     = 1'b0;
        stalls   = 0;
        recv_val = 1'b1;
        recv_msg = d;
        send_rdy = s;
        for (int k = 0; k < 20 && !done; k++) begin
            #3;
            done = recv_rdy;
            step();
            if (!done) stalls++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: sample %h not accepted, required acceptance within 20 cycles", d);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int st;
        int total;
        reset    = 1'b0;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_recv_rdy", recv_rdy, 1'b1);
        check("rst_send_val", send_val, 1'b0);
        check("rst_send_msg0", send_msg[0], 32'h0);
        check("rst_state", dbg_state, COLLECT);
        reset = 1'b1;
        step();

        // Basic frame 0x10..0x17, consumer ready.
        for (int i = 0; i < N; i++) push(32'h10 + i, 1'b1, st);
        check("basic_send_val", send_val, 1'b1);
        check("basic_recv_rdy", recv_rdy, OVERLAP ? 1'b1 : 1'b0);
        check("basic_state", dbg_state, HOLD);
        for (int i = 0; i < N; i++) check($sformatf("basic_msg[%0d]", i), send_msg[i], 32'h10 + i);
        recv_val = 1'b0;
        step();
        check("basic_after_val", send_val, 1'b0);
        check("basic_after_rdy", recv_rdy, 1'b1);

        // Backpressure: frame 0x20..0x27 held for 5 cycles, 0xDEAD ignored.
        for (int i = 0; i < N; i++) push(32'h20 + i, 1'b0, st);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'hDEAD, 1'b0);
            check("bp_send_val", send_val, 1'b1);
            check("bp_recv_rdy", recv_rdy, 1'b0);
            check("bp_msg0", send_msg[0], 32'h20);
            check("bp_msg7", send_msg[7], 32'h27);
        end
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < N; i++) push(32'h30 + i, 1'b1, st);
        check("bp_next_val", send_val, 1'b1);
        check("bp_next_msg0", send_msg[0], 32'h30);
        check("bp_next_msg7", send_msg[7], 32'h37);
        recv_val = 1'b0;
        step();

        // Gapped input: valid toggles 1/0 across 8 samples.
        for (int i = 0; i < N; i++) begin
            push(32'h40 + i, 1'b1, st);
            if (i < N - 1) begin
                drive(1'b0, 32'h99, 1'b1);
                check("gap_no_val", send_val, 1'b0);
            end
        end
        check("gap_send_val", send_val, 1'b1);
        for (int i = 0; i < N; i++) check($sformatf("gap_msg[%0d]", i), send_msg[i], 32'h40 + i);
        recv_val = 1'b0;
        step();

        // Reset mid-frame, between clock edges.
        for (int i = 0; i < 3; i++) push(32'h50 + i, 1'b1, st);
        recv_val = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("midrst_recv_rdy", recv_rdy, 1'b1);
        check("midrst_send_val", send_val, 1'b0);
        check("midrst_state", dbg_state, COLLECT);
        for (int i = 0; i < N; i++) check($sformatf("midrst_msg[%0d]", i), send_msg[i], 32'h0);
        #1 reset = 1'b1;
        step();
        for (int i = 0; i < N; i++) push(32'h60 + i, 1'b1, st);
        for (int i = 0; i < N; i++) check($sformatf("postrst_msg[%0d]", i), send_msg[i], 32'h60 + i);
        recv_val = 1'b0;
        step();

        // Streaming two frames 0x00..0x0F with the consumer always ready.
        total = 0;
        for (int i = 0; i < 2 * N; i++) begin
            push(BW'(i), 1'b1, st);
            total += st;
        end
        check("stream_bubbles", BW'(total), OVERLAP ? 32'd0 : 32'd1);
        check("stream_send_val", send_val, 1'b1);
        check("stream_msg0", send_msg[0], 32'h08);
        check("stream_msg7", send_msg[7], 32'h0F);
        recv_val = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
